// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Tracks in-flight register writes from issue (ID->EX) to writeback across
//   DEPTH post-ID slots (slot 0 = EX ... slot DEPTH-1 = WB). Each cycle it
//   decides whether the instruction in ID stalls. When forwarding is enabled,
//   it also picks the forwarding source for each operand.
//
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   id_valid                 ID holds a real instruction
//   id_rs1/id_rs2            source registers; *_used marks a real read
//   id_rd, id_regwrite       destination and write enable of the ID instruction
//   id_memread               ID instruction is a load (data ready from slot 1)
//   flush                    squash ID and slot 0 this cycle
//   stall                    hold IF/ID, bubble into EX
//   issue                    id_valid & ~stall & ~flush
//   fwd_sel1/fwd_sel2        0 = register file, k = result of slot k-1
//   stall_count              saturating count of stalled cycles
module hazard_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int DEPTH      = 3,
  parameter int FORWARD    = 0,
  parameter int CNT_W      = 16,
  parameter int SEL_W      = $clog2(DEPTH+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  flush,
  output logic                  stall,
  output logic                  issue,
  output logic [SEL_W-1:0]      fwd_sel1,
  output logic [SEL_W-1:0]      fwd_sel2,
  output logic [CNT_W-1:0]      stall_count
);

  typedef struct packed {
    logic                  vld;
    logic [REG_ADDR_W-1:0] rd;
    logic                  ld;
  } slot_t;

  slot_t            slot_q [DEPTH];
  slot_t            slot_d [DEPTH];
  logic [DEPTH-1:0] hit1, hit2;
  logic             haz;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A hit needs a nonzero source, so comparing rd against it also enforces
  // the "live slot means rd != 0" rule without a separate term.
  always_comb begin
    hit1 = '0;
    hit2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      hit1[k] = id_valid && id_rs1_used && (id_rs1 != '0) &&
                slot_q[k].vld && (slot_q[k].rd == id_rs1);
      hit2[k] = id_valid && id_rs2_used && (id_rs2 != '0) &&
                slot_q[k].vld && (slot_q[k].rd == id_rs2);
    end
  end

  always_comb begin
    if (FORWARD == 0) haz = (|hit1) || (|hit2);
    else              haz = (hit1[0] || hit2[0]) && slot_q[0].ld;  // load-use only
    stall = haz && !flush;
    issue = id_valid && !haz && !flush;

    // Scan oldest to youngest so the youngest matching slot overwrites.
    fwd_sel1 = '0;
    fwd_sel2 = '0;
    if (FORWARD != 0) begin
      for (int k = DEPTH-1; k >= 0; k--) begin
        if (hit1[k]) fwd_sel1 = SEL_W'(k+1);
        if (hit2[k]) fwd_sel2 = SEL_W'(k+1);
      end
    end
  end

  // Slots always shift; a stall only withholds the new entry. Writes to
  // register 0 never become valid. A flush kills the current EX entry on
  // its way into slot 1.
  always_comb begin
    slot_d[0] = '0;
    if (issue && id_regwrite && (id_rd != '0))
      slot_d[0] = '{vld: 1'b1, rd: id_rd, ld: id_memread};
    for (int k = 1; k < DEPTH; k++)
      slot_d[k] = (k == 1 && flush) ? '0 : slot_q[k-1];
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) slot_q[k] <= '0;
      cnt_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) slot_q[k] <= slot_d[k];
      cnt_q <= cnt_d;
    end
  end

  assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  localparam int NI = 3;
  localparam int DEP  [NI] = '{3, 3, 1};
  localparam int FWD  [NI] = '{0, 1, 1};
  localparam int CMAX [NI] = '{15, 65535, 255};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0, id_rs1_used = 1'b0, id_rs2_used = 1'b0;
  logic       id_regwrite = 1'b0, id_memread = 1'b0, flush = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;

  logic        st_a, is_a, st_b, is_b, st_c, is_c;
  logic [1:0]  s1_a, s2_a, s1_b, s2_b;
  logic [0:0]  s1_c, s2_c;
  logic [3:0]  cnt_a;
  logic [15:0] cnt_b;
  logic [7:0]  cnt_c;

  hazard_scoreboard #(.REG_ADDR_W(5), .DEPTH(3), .FORWARD(0), .CNT_W(4)) u_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .stall(st_a), .issue(is_a), .fwd_sel1(s1_a), .fwd_sel2(s2_a), .stall_count(cnt_a));

  hazard_scoreboard #(.REG_ADDR_W(5), .DEPTH(3), .FORWARD(1), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .stall(st_b), .issue(is_b), .fwd_sel1(s1_b), .fwd_sel2(s2_b), .stall_count(cnt_b));

  hazard_scoreboard #(.REG_ADDR_W(5), .DEPTH(1), .FORWARD(1), .CNT_W(8)) u_c (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .stall(st_c), .issue(is_c), .fwd_sel1(s1_c), .fwd_sel2(s2_c), .stall_count(cnt_c));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: a history of what was issued k+1 cycles ago, with a
  // flag marking entries squashed by a flush while they sat in EX.
  typedef struct {
    bit w;
    int rd;
    bit ld;
    bit killed;
  } rec_t;

  rec_t hist [NI][8];
  int   cnt_m [NI];
  bit   e_stall [NI], e_issue [NI];
  int   e_s1 [NI], e_s2 [NI];
  bit   o_stall [NI], o_issue [NI];
  int   o_s1 [NI], o_s2 [NI], o_cnt [NI];

  function automatic void src_eval(input int i, input bit used, input int src,
                                   output bit any, output bit ld0, output int best);
    any = 0; ld0 = 0; best = -1;
    if (!(id_valid && used && src != 0)) return;
    for (int k = 0; k < DEP[i]; k++) begin
      if (hist[i][k].w && !hist[i][k].killed && hist[i][k].rd == src) begin
        any = 1;
        if (best < 0) best = k;
        if (k == 0 && hist[i][k].ld) ld0 = 1;
      end
    end
  endfunction

  function automatic void model_eval();
    bit a1, a2, l1, l2, hz;
    int b1, b2;
    for (int i = 0; i < NI; i++) begin
      src_eval(i, id_rs1_used, int'(id_rs1), a1, l1, b1);
      src_eval(i, id_rs2_used, int'(id_rs2), a2, l2, b2);
      hz = FWD[i] ? (l1 | l2) : (a1 | a2);
      e_stall[i] = hz && !flush;
      e_issue[i] = id_valid && !hz && !flush;
      e_s1[i] = (FWD[i] && b1 >= 0) ? b1 + 1 : 0;
      e_s2[i] = (FWD[i] && b2 >= 0) ? b2 + 1 : 0;
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NI; i++) begin
      cnt_m[i] = 0;
      for (int k = 0; k < 8; k++) hist[i][k] = '{0, 0, 0, 0};
    end
  endfunction

  function automatic void model_clock();
    for (int i = 0; i < NI; i++) begin
      if (e_stall[i] && cnt_m[i] < CMAX[i]) cnt_m[i]++;
      if (flush) hist[i][0].killed = 1;
      for (int k = 7; k > 0; k--) hist[i][k] = hist[i][k-1];
      hist[i][0] = '{e_issue[i] && id_regwrite && id_rd != 0, int'(id_rd), id_memread, 0};
    end
  endfunction

  // One cycle: inputs already applied; compare at negedge, advance at posedge.
  task automatic step();
    string nm;
    model_eval();
    @(negedge clk);
    o_stall = '{st_a, st_b, st_c};
    o_issue = '{is_a, is_b, is_c};
    o_s1 = '{int'(s1_a), int'(s1_b), int'(s1_c)};
    o_s2 = '{int'(s2_a), int'(s2_b), int'(s2_c)};
    o_cnt = '{int'(cnt_a), int'(cnt_b), int'(cnt_c)};
    for (int i = 0; i < NI; i++) begin
      nm = $sformatf("u%0d", i);
      chk({nm, ".stall"}, int'(o_stall[i]), int'(e_stall[i]));
      chk({nm, ".issue"}, int'(o_issue[i]), int'(e_issue[i]));
      chk({nm, ".fwd1"}, o_s1[i], e_s1[i]);
      chk({nm, ".fwd2"}, o_s2[i], e_s2[i]);
      chk({nm, ".cnt"}, o_cnt[i], cnt_m[i]);
    end
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic set_in(input bit v, input int rs1, input bit u1, input int rs2,
                        input bit u2, input int rd, input bit w, input bit ld,
                        input bit fl);
    id_valid = v; id_rs1 = 5'(rs1); id_rs1_used = u1; id_rs2 = 5'(rs2);
    id_rs2_used = u2; id_rd = 5'(rd); id_regwrite = w; id_memread = ld; flush = fl;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  int n;

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst.stall", int'(st_a | st_b | st_c), 0);
    chk("rst.cnt", int'(cnt_a) + int'(cnt_b) + int'(cnt_c), 0);
    chk("rst.fwd", int'(s1_b) + int'(s2_b), 0);
    do_reset();

    // RAW at distance 1 without forwarding: DEPTH stall cycles.
    set_in(1, 0, 0, 0, 0, 5, 1, 0, 0); step();
    set_in(1, 5, 1, 0, 0, 0, 0, 0, 0);
    n = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (o_stall[0]) n++;
      else break;
    end
    chk("raw.nstall", n, 3);
    chk("raw.issue", int'(o_issue[0]), 1);
    chk("raw.fwd1", o_s1[0], 0);
    chk("raw.cnt", o_cnt[0], 3);

    // x0 writes/reads and unused sources never stall.
    do_reset();
    set_in(1, 0, 0, 0, 0, 0, 1, 0, 0); step();
    set_in(1, 0, 1, 0, 1, 0, 0, 0, 0); step();
    chk("x0.stall", int'(o_stall[0]), 0);
    set_in(1, 0, 0, 0, 0, 7, 1, 0, 0); step();
    set_in(1, 7, 0, 0, 0, 0, 0, 0, 0); step();
    chk("unused.stall", int'(o_stall[0]), 0);

    // Forwarding from back-to-back ALU producers.
    do_reset();
    set_in(1, 0, 0, 0, 0, 5, 1, 0, 0); step();
    set_in(1, 0, 0, 0, 0, 6, 1, 0, 0); step();
    set_in(1, 6, 1, 5, 1, 0, 0, 0, 0); step();
    chk("fwd.stall", int'(o_stall[1]), 0);
    chk("fwd.sel1", o_s1[1], 1);
    chk("fwd.sel2", o_s2[1], 2);
    do_reset();
    set_in(1, 0, 0, 0, 0, 5, 1, 0, 0); step();
    set_in(1, 0, 0, 0, 0, 1, 1, 0, 0); step();
    set_in(1, 0, 0, 0, 0, 5, 1, 0, 0); step();
    set_in(1, 5, 1, 0, 0, 0, 0, 0, 0); step();
    chk("young.sel1", o_s1[1], 1);

    // Load-use with forwarding: one stall, then forward from slot 1.
    do_reset();
    set_in(1, 0, 0, 0, 0, 9, 1, 1, 0); step();
    set_in(1, 9, 1, 0, 0, 0, 0, 0, 0); step();
    chk("lu.stall", int'(o_stall[1]), 1);
    step();
    chk("lu.issue", int'(o_issue[1]), 1);
    chk("lu.sel1", o_s1[1], 2);
    chk("lu.cnt", o_cnt[1], 1);

    // Flush in the middle of a stall.
    do_reset();
    set_in(1, 0, 0, 0, 0, 5, 1, 0, 0); step();
    set_in(1, 5, 1, 0, 0, 0, 0, 0, 0); step();
    chk("fl.pre", int'(o_stall[0]), 1);
    flush = 1'b1; step();
    chk("fl.stall", int'(o_stall[0]), 0);
    chk("fl.issue", int'(o_issue[0]), 0);
    flush = 1'b0; step();
    chk("fl.post", int'(o_stall[0]), 1);
    step();
    chk("fl.done", int'(o_issue[0]), 1);

    // Asynchronous reset while stalled.
    do_reset();
    set_in(1, 0, 0, 0, 0, 5, 1, 0, 0); step();
    set_in(1, 5, 1, 0, 0, 0, 0, 0, 0); step();
    #2 rst = 1'b1;
    #1;
    chk("arst.stall", int'(st_a), 0);
    chk("arst.cnt", int'(cnt_a), 0);
    chk("arst.issue", int'(is_a), 1);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;

    // addi x5,x5,1 held in ID: near-continuous hazard saturates the 4-bit counter.
    do_reset();
    set_in(1, 5, 1, 0, 0, 5, 1, 0, 0);
    for (int c = 0; c < 24; c++) step();
    chk("sat.cnt", o_cnt[0], 15);

    // Random traffic on a small register window to provoke hazards.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      set_in($urandom_range(9, 0) < 8, $urandom_range(7, 0), $urandom_range(9, 0) < 7,
             $urandom_range(7, 0), $urandom_range(9, 0) < 7, $urandom_range(7, 0),
             $urandom_range(9, 0) < 7, $urandom_range(9, 0) < 3, $urandom_range(9, 0) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
